mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit between the EX/MEM pipeline register and the word-wide data memory (256 x 32, combinational read, posedge write).
- Adds byte and halfword loads (signed/unsigned) and byte/halfword stores on top of the word-only memory.
- Sub-word stores use a 2-cycle read-modify-write (RMW) sequence that stalls the pipeline for one cycle.
- Word accesses pass straight through with no stall.

Parameters:
- BIG_ENDIAN, 0, byte-lane order. 0: byte k sits at bits [8k+7:8k], k=Address[1:0]. 1: lane index is 3-k.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load request from EX/MEM.
- MemWrite  in  1  store request from EX/MEM.
- MemSize  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- MemSigned  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- Address  in  32  byte address.
- StoreData  in  32  store source (rt); sub-word data is in the low bits.
- dm_MemRead  out  1  read enable to data memory.
- dm_MemWrite  out  1  write enable to data memory.
- dm_Address  out  32  word-aligned address, {Address[31:2],2'b00}.
- dm_WriteData  out  32  full word to write.
- dm_ReadData  in  32  combinational read data from memory.
- LoadData  out  32  extended load result to MEM/WB.
- Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- MisalignExc  out  1  misaligned/illegal access this cycle.
- BadAddr  out  32  registered address of the last misaligned access.

Behaviour:
- FSM states: IDLE, RMW_WR. The state register and the 32-bit merge register are reset asynchronously (state to IDLE, merge to 0).
- While rst_n=0, all outputs are 0.
- Upstream holds all inputs stable while Stall=1.
- MemRead and MemWrite both high: the write takes priority and LoadData=0.
- IDLE, word load: dm_MemRead=1. LoadData=dm_ReadData in the same cycle. Zero latency, no stall.
- IDLE, sub-word load: dm_MemRead=1. Select the lane from dm_ReadData, then extend per MemSigned. Halfword lane select uses Address[1] (byte pair). Same cycle, no stall.
- IDLE, word store: dm_MemWrite=1, dm_WriteData=StoreData. The write commits at the next edge, no stall.
- IDLE, sub-word store (cycle 1):
  - dm_MemRead=1, dm_MemWrite=0, Stall=1.
  - Merge register <= dm_ReadData with the selected lane(s) replaced by StoreData[7:0] or StoreData[15:0].
  - Next state RMW_WR.
- RMW_WR (cycle 2):
  - dm_MemWrite=1, dm_WriteData=merge register, dm_MemRead=0, Stall=0.
  - Next state IDLE. The pipeline advances at the same edge.
- Idle bus: when neither MemRead nor MemWrite is high, dm_* enables are 0 and LoadData=0.
- dm_Address is always the word-aligned input address. The memory itself uses only Address[9:2]; addresses wrap modulo 1 KiB.
- Asynchronous reset asserted in RMW_WR before the edge: the write is abandoned, memory is unmodified, and the FSM returns to IDLE.
- Back-to-back sub-word stores: each costs 2 cycles. The second store's read sees the first store's committed word.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Misaligned/illegal conditions: halfword with Address[0]=1; word with Address[1:0]!=0; MemSize=11.
- Defined:
  - MisalignExc=1 combinationally in the access cycle.
  - dm_MemRead=dm_MemWrite=0, LoadData=0, Stall=0, no RMW started.
  - BadAddr <= Address at the next edge; it holds until the next trap or reset (reset value 0).
- Undefined:
  - MisalignExc and BadAddr are tied 0.
  - Low address bits below the access size are ignored (forced aligned).
  - MemSize=11 is treated as word.

Test Plan:
1. Memory[0x10]=0x80FF7F01; LB 0x11 -> 0x0000007F; LB 0x12 -> 0xFFFFFFFF; LBU 0x12 -> 0x000000FF; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01. All in the same cycle, Stall=0.
2. Memory[0x10]=0x11223344; SB 0x11, StoreData=0x000000AB:
   - cycle 1: Stall=1, dm_MemRead=1.
   - cycle 2: dm_MemWrite=1, dm_WriteData=0x1122AB44.
   - LW 0x10 then returns 0x1122AB44.
3. SW 0x20, StoreData=0xDEADBEEF -> one cycle, Stall never high; LW 0x20 -> 0xDEADBEEF. With BIG_ENDIAN=1, LB 0x20 -> 0xFFFFFFDE.
4. SH 0x12, StoreData=0x0000CAFE, then SH 0x10, StoreData=0x0000BEEF, back-to-back -> 4 cycles with 2 stall cycles; word 0x10 = 0xCAFEBEEF.
5. With MISALIGN_TRAP_EN, LH 0x11 -> MisalignExc=1, no dm enables, BadAddr=0x00000011 next cycle. Without the macro, LH 0x11 returns the halfword at 0x10.
6. SB 0x14 in progress; pull rst_n low during RMW_WR before the edge -> memory[0x14] unchanged, Stall=0, all outputs 0; after release, an SB 0x14 retry completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: sub-word loads with sign/zero extension, and sub-word stores
// done as a 2-cycle read-modify-write. Optional alignment trap via `define MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic        dm_MemRead,
    output logic        dm_MemWrite,
    output logic [31:0] dm_Address,
    output logic [31:0] dm_WriteData,
    input  logic [31:0] dm_ReadData,
    output logic [31:0] LoadData,
    output logic        Stall,
    output logic        MisalignExc,
    output logic [31:0] BadAddr
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [DATA_W-1:0] mergeReg;
    logic [DATA_W-1:0] mergedWord;
    logic [DATA_W-1:0] loadExt;
    logic [1:0]        byteLane;
    logic              halfLane;
    logic [7:0]        byteVal;
    logic [15:0]       halfVal;
    logic              isByte;
    logic              isHalf;
    logic              misalign;
    logic              rmwStart;
    logic              trapNow;
    logic              dmReadC;
    logic              dmWriteC;
    logic [DATA_W-1:0] wdataC;
    logic [DATA_W-1:0] loadC;
    logic              stallC;

    assign isByte = (MemSize == 2'b00);
    assign isHalf = (MemSize == 2'b01);

    // Lane selection; the low address bits below the access size are simply not consulted.
    assign byteLane = (BIG_ENDIAN != 0) ? ~Address[1:0] : Address[1:0];
    assign halfLane = (BIG_ENDIAN != 0) ? ~Address[1]   : Address[1];
    assign byteVal  = dm_ReadData[{byteLane, 3'b000} +: 8];
    assign halfVal  = dm_ReadData[{halfLane, 4'b0000} +: 16];

`ifdef MISALIGN_TRAP_EN
    assign misalign = (MemRead || MemWrite) &&
                      ((isHalf && Address[0]) ||
                       ((MemSize == 2'b10) && (Address[1:0] != 2'b00)) ||
                       (MemSize == 2'b11));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        loadExt = dm_ReadData;
        if (isByte) begin
            loadExt = MemSigned ? {{24{byteVal[7]}}, byteVal} : {24'b0, byteVal};
        end else if (isHalf) begin
            loadExt = MemSigned ? {{16{halfVal[15]}}, halfVal} : {16'b0, halfVal};
        end
    end

    always_comb begin
        mergedWord = dm_ReadData;
        if (isByte) begin
            mergedWord[{byteLane, 3'b000} +: 8] = StoreData[7:0];
        end else begin
            mergedWord[{halfLane, 4'b0000} +: 16] = StoreData[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mergeReg <= '0;
        end else begin
            state <= nextState;
            if (rmwStart) begin
                mergeReg <= mergedWord;
            end
        end
    end

    // Next state and bus control; a write wins over a simultaneous read.
    always_comb begin
        nextState = state;
        dmReadC   = 1'b0;
        dmWriteC  = 1'b0;
        wdataC    = '0;
        loadC     = '0;
        stallC    = 1'b0;
        rmwStart  = 1'b0;
        trapNow   = 1'b0;
        case (state)
            IDLE: begin
                if (misalign) begin
                    trapNow = 1'b1;
                end else if (MemWrite) begin
                    if (isByte || isHalf) begin
                        dmReadC   = 1'b1;
                        stallC    = 1'b1;
                        rmwStart  = 1'b1;
                        nextState = RMW_WR;
                    end else begin
                        dmWriteC = 1'b1;
                        wdataC   = StoreData;
                    end
                end else if (MemRead) begin
                    dmReadC = 1'b1;
                    loadC   = loadExt;
                end
            end
            RMW_WR: begin
                dmWriteC  = 1'b1;
                wdataC    = mergeReg;
                nextState = IDLE;
            end
        endcase
    end

    // Reset forces every output low, which also abandons an in-flight RMW write.
    assign dm_MemRead   = rst_n & dmReadC;
    assign dm_MemWrite  = rst_n & dmWriteC;
    assign dm_Address   = rst_n ? {Address[31:2], 2'b00} : '0;
    assign dm_WriteData = rst_n ? wdataC : '0;
    assign LoadData     = rst_n ? loadC : '0;
    assign Stall        = rst_n & stallC;
    assign MisalignExc  = rst_n & trapNow;

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BadAddr <= '0;
        end else if (trapNow) begin
            BadAddr <= Address;
        end
    end
`else
    assign BadAddr = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-cycle vectors plus hand-written
// RMW, back-to-back, alignment and reset-abort sequences against a behavioural 256x32 memory.
module tb_mem_access_unit;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] expLoad;
        logic        expRd;
        logic        expWr;
        logic [31:0] expWd;
    } vecT;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Address;
    logic [31:0] StoreData;

    logic        dmMemRead,  beMemRead;
    logic        dmMemWrite, beMemWrite;
    logic [31:0] dmAddress,  beAddress;
    logic [31:0] dmWriteData, beWriteData;
    logic [31:0] dmReadData, beReadData;
    logic [31:0] loadData,   beLoadData;
    logic        stall,      beStall;
    logic        misExc,     beMisExc;
    logic [31:0] badAddr,    beBadAddr;

    logic [31:0] mem [0:255];

    int tests = 0;
    int fails = 0;
    int stallCycles;

    vecT vecs [0:17];

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .Address(Address), .StoreData(StoreData),
        .dm_MemRead(dmMemRead), .dm_MemWrite(dmMemWrite), .dm_Address(dmAddress),
        .dm_WriteData(dmWriteData), .dm_ReadData(dmReadData),
        .LoadData(loadData), .Stall(stall), .MisalignExc(misExc), .BadAddr(badAddr)
    );

    // Big-endian instance shares the memory read path but never writes it.
    mem_access_unit #(.BIG_ENDIAN(1)) dutBe (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .Address(Address), .StoreData(StoreData),
        .dm_MemRead(beMemRead), .dm_MemWrite(beMemWrite), .dm_Address(beAddress),
        .dm_WriteData(beWriteData), .dm_ReadData(beReadData),
        .LoadData(beLoadData), .Stall(beStall), .MisalignExc(beMisExc), .BadAddr(beBadAddr)
    );

    assign dmReadData = mem[dmAddress[9:2]];
    assign beReadData = mem[beAddress[9:2]];

    always @(posedge clk) begin
        if (dmMemWrite) mem[dmAddress[9:2]] <= dmWriteData;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vecT mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                               input logic [31:0] expLoad, input logic expRd, input logic expWr,
                               input logic [31:0] expWd);
        vecT v;
        v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.sd = sd;
        v.expLoad = expLoad; v.expRd = expRd; v.expWr = expWr; v.expWd = expWd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setIn(input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] sd);
        MemRead = rd; MemWrite = wr; MemSize = size; MemSigned = sgn;
        Address = addr; StoreData = sd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 1, SZ_W, 0, 32'h10,  32'h80FF7F01, 32'h0,        0, 1, 32'h80FF7F01);
        vecs[1]  = mk(1, 0, SZ_B, 1, 32'h11,  32'h0,        32'h0000007F, 1, 0, 32'h0);
        vecs[2]  = mk(1, 0, SZ_B, 1, 32'h12,  32'h0,        32'hFFFFFFFF, 1, 0, 32'h0);
        vecs[3]  = mk(1, 0, SZ_B, 0, 32'h12,  32'h0,        32'h000000FF, 1, 0, 32'h0);
        vecs[4]  = mk(1, 0, SZ_H, 1, 32'h12,  32'h0,        32'hFFFF80FF, 1, 0, 32'h0);
        vecs[5]  = mk(1, 0, SZ_H, 0, 32'h10,  32'h0,        32'h00007F01, 1, 0, 32'h0);
        vecs[6]  = mk(1, 0, SZ_W, 0, 32'h10,  32'h0,        32'h80FF7F01, 1, 0, 32'h0);
        vecs[7]  = mk(1, 0, SZ_B, 1, 32'h13,  32'h0,        32'hFFFFFF80, 1, 0, 32'h0);
        vecs[8]  = mk(0, 1, SZ_W, 0, 32'h20,  32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF);
        vecs[9]  = mk(1, 0, SZ_W, 0, 32'h20,  32'h0,        32'hDEADBEEF, 1, 0, 32'h0);
        vecs[10] = mk(1, 0, SZ_H, 1, 32'h22,  32'h0,        32'hFFFFDEAD, 1, 0, 32'h0);
        vecs[11] = mk(1, 0, SZ_B, 0, 32'h23,  32'h0,        32'h000000DE, 1, 0, 32'h0);
        vecs[12] = mk(0, 0, SZ_W, 0, 32'h20,  32'h0000FFFF, 32'h0,        0, 0, 32'h0);
        vecs[13] = mk(1, 1, SZ_W, 0, 32'h24,  32'h12345678, 32'h0,        0, 1, 32'h12345678);
        vecs[14] = mk(1, 0, SZ_W, 0, 32'h24,  32'h0,        32'h12345678, 1, 0, 32'h0);
        vecs[15] = mk(1, 0, SZ_H, 0, 32'h412, 32'h0,        32'h000080FF, 1, 0, 32'h0);
        vecs[16] = mk(0, 1, SZ_W, 0, 32'h14,  32'h01020304, 32'h0,        0, 1, 32'h01020304);
        vecs[17] = mk(0, 1, SZ_W, 0, 32'h10,  32'h11223344, 32'h0,        0, 1, 32'h11223344);

        // Reset: outputs low even with a load requested.
        rst_n = 1'b0;
        setIn(1, 0, SZ_W, 0, 32'h10, 32'h0);
        #12;
        check("rst LoadData", loadData, 32'h0);
        check("rst dm_MemRead", {31'b0, dmMemRead}, 32'h0);
        check("rst dm_Address", dmAddress, 32'h0);
        check("rst Stall", {31'b0, stall}, 32'h0);
        check("rst MisalignExc", {31'b0, misExc}, 32'h0);
        check("rst BadAddr", badAddr, 32'h0);
        nextCycle();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            setIn(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].sd);
            #3;
            check($sformatf("v%0d LoadData", i), loadData, vecs[i].expLoad);
            check($sformatf("v%0d dm_MemRead", i), {31'b0, dmMemRead}, {31'b0, vecs[i].expRd});
            check($sformatf("v%0d dm_MemWrite", i), {31'b0, dmMemWrite}, {31'b0, vecs[i].expWr});
            check($sformatf("v%0d dm_Address", i), dmAddress, {vecs[i].addr[31:2], 2'b00});
            check($sformatf("v%0d Stall", i), {31'b0, stall}, 32'h0);
            check($sformatf("v%0d MisalignExc", i), {31'b0, misExc}, 32'h0);
            if (vecs[i].expWr) check($sformatf("v%0d dm_WriteData", i), dmWriteData, vecs[i].expWd);
            nextCycle();
        end

        // SB 0x11 read-modify-write on 0x11223344.
        setIn(0, 1, SZ_B, 0, 32'h11, 32'h000000AB);
        #3;
        check("sb c1 Stall", {31'b0, stall}, 32'h1);
        check("sb c1 dm_MemRead", {31'b0, dmMemRead}, 32'h1);
        check("sb c1 dm_MemWrite", {31'b0, dmMemWrite}, 32'h0);
        nextCycle();
        #3;
        check("sb c2 Stall", {31'b0, stall}, 32'h0);
        check("sb c2 dm_MemRead", {31'b0, dmMemRead}, 32'h0);
        check("sb c2 dm_MemWrite", {31'b0, dmMemWrite}, 32'h1);
        check("sb c2 dm_WriteData", dmWriteData, 32'h1122AB44);
        check("sb c2 BE dm_WriteData", beWriteData, 32'h11AB3344);
        nextCycle();
        setIn(1, 0, SZ_W, 0, 32'h10, 32'h0);
        #3;
        check("sb LW 0x10", loadData, 32'h1122AB44);
        nextCycle();

        // Endianness of the same byte address.
        setIn(1, 0, SZ_B, 1, 32'h20, 32'h0);
        #3;
        check("LE LB 0x20", loadData, 32'hFFFFFFEF);
        check("BE LB 0x20", beLoadData, 32'hFFFFFFDE);
        nextCycle();

        // Back-to-back halfword stores.
        stallCycles = 0;
        setIn(0, 1, SZ_H, 0, 32'h12, 32'h0000CAFE);
        #3;
        if (stall) stallCycles++;
        nextCycle();
        #3;
        if (stall) stallCycles++;
        check("sh1 dm_WriteData", dmWriteData, 32'hCAFEAB44);
        nextCycle();
        setIn(0, 1, SZ_H, 0, 32'h10, 32'h0000BEEF);
        #3;
        if (stall) stallCycles++;
        check("sh2 c1 dm_MemWrite", {31'b0, dmMemWrite}, 32'h0);
        nextCycle();
        #3;
        if (stall) stallCycles++;
        check("sh2 c2 dm_WriteData", dmWriteData, 32'hCAFEBEEF);
        nextCycle();
        check("b2b stall cycles", stallCycles, 32'd2);
        setIn(1, 0, SZ_W, 0, 32'h10, 32'h0);
        #3;
        check("b2b LW 0x10", loadData, 32'hCAFEBEEF);
        nextCycle();

        // Misaligned / illegal accesses.
        setIn(1, 0, SZ_H, 1, 32'h11, 32'h0);
        #3;
`ifdef MISALIGN_TRAP_EN
        check("LH 0x11 MisalignExc", {31'b0, misExc}, 32'h1);
        check("LH 0x11 dm_MemRead", {31'b0, dmMemRead}, 32'h0);
        check("LH 0x11 LoadData", loadData, 32'h0);
        check("LH 0x11 Stall", {31'b0, stall}, 32'h0);
        nextCycle();
        setIn(0, 0, SZ_W, 0, 32'h0, 32'h0);
        #3;
        check("BadAddr after LH", badAddr, 32'h00000011);
        nextCycle();
        setIn(0, 1, SZ_W, 0, 32'h22, 32'h55667788);
        #3;
        check("SW 0x22 MisalignExc", {31'b0, misExc}, 32'h1);
        check("SW 0x22 dm_MemWrite", {31'b0, dmMemWrite}, 32'h0);
        nextCycle();
        setIn(1, 0, 2'b11, 0, 32'h10, 32'h0);
        #3;
        check("size11 MisalignExc", {31'b0, misExc}, 32'h1);
        check("BadAddr after SW", badAddr, 32'h00000022);
        nextCycle();
        setIn(1, 0, SZ_W, 0, 32'h20, 32'h0);
        #3;
        check("trap LW 0x20", loadData, 32'hDEADBEEF);
        check("BadAddr after size11", badAddr, 32'h00000010);
        nextCycle();
`else
        check("LH 0x11 LoadData", loadData, 32'hFFFFBEEF);
        check("LH 0x11 MisalignExc", {31'b0, misExc}, 32'h0);
        check("LH 0x11 dm_MemRead", {31'b0, dmMemRead}, 32'h1);
        nextCycle();
        setIn(0, 1, SZ_W, 0, 32'h22, 32'h55667788);
        #3;
        check("SW 0x22 dm_Address", dmAddress, 32'h00000020);
        check("SW 0x22 Stall", {31'b0, stall}, 32'h0);
        nextCycle();
        setIn(1, 0, 2'b11, 0, 32'h10, 32'h0);
        #3;
        check("size11 LoadData", loadData, 32'hCAFEBEEF);
        nextCycle();
        setIn(1, 0, SZ_W, 0, 32'h20, 32'h0);
        #3;
        check("LW 0x20 after SW 0x22", loadData, 32'h55667788);
        check("BadAddr tied", badAddr, 32'h0);
        nextCycle();
`endif

        // Reset during RMW_WR abandons the write.
        setIn(0, 1, SZ_B, 0, 32'h14, 32'h0000005A);
        #3;
        check("abort c1 Stall", {31'b0, stall}, 32'h1);
        nextCycle();
        rst_n = 1'b0;
        #2;
        check("abort Stall", {31'b0, stall}, 32'h0);
        check("abort dm_MemWrite", {31'b0, dmMemWrite}, 32'h0);
        check("abort dm_WriteData", dmWriteData, 32'h0);
        check("abort dm_Address", dmAddress, 32'h0);
        setIn(0, 0, SZ_W, 0, 32'h0, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        setIn(1, 0, SZ_W, 0, 32'h14, 32'h0);
        #3;
        check("abort mem 0x14", loadData, 32'h01020304);
        nextCycle();
        setIn(0, 1, SZ_B, 0, 32'h14, 32'h0000005A);
        #3;
        check("retry c1 Stall", {31'b0, stall}, 32'h1);
        nextCycle();
        #3;
        check("retry c2 dm_WriteData", dmWriteData, 32'h0102035A);
        nextCycle();
        setIn(1, 0, SZ_W, 0, 32'h14, 32'h0);
        #3;
        check("retry LW 0x14", loadData, 32'h0102035A);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
